// File: rtl/apb4_master_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : apb4_master_bridge_if
//  Purpose  : Bundles the request/response command port and the APB4 bus
//             driven by apb4_master_bridge.
//  Signals  : req_*  - valid/ready request channel (addr, data, strb, prot)
//             rsp_*  - valid/ready response channel (rdata, err)
//             p*     - APB4 initiator signals
//  Modports : master - the bridge's view (drives req_ready, rsp_*, APB outputs)
//             slave  - the environment's view (requester plus APB completer)
//  Revision : 1.0 - initial release
// ============================================================================
interface apb4_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Command request channel
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_write_i;
  logic [ADDR_WIDTH-1:0]   req_addr_i;
  logic [DATA_WIDTH-1:0]   req_wdata_i;
  logic [DATA_WIDTH/8-1:0] req_strb_i;
  logic [2:0]              req_prot_i;
  // Command response channel
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_rdata_o;
  logic                    rsp_err_o;
  // APB4 bus
  logic [ADDR_WIDTH-1:0]   paddr_o;
  logic [2:0]              pprot_o;
  logic                    psel_o;
  logic                    penable_o;
  logic                    pwrite_o;
  logic [DATA_WIDTH-1:0]   pwdata_o;
  logic [DATA_WIDTH/8-1:0] pstrb_o;
  logic                    pready_i;
  logic [DATA_WIDTH-1:0]   prdata_i;
  logic                    pslverr_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_ready_i,
    output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_ready_i,
    input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output pready_i, prdata_i, pslverr_i
  );
endinterface
`default_nettype wire

// File: rtl/apb4_master_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : apb4_master_bridge
//  Purpose  : Single-outstanding APB4 initiator. Each accepted command becomes
//             one SETUP + ACCESS transfer; the result is returned on the
//             response channel and held until consumed.
//  Ports    : pclk    - APB clock (only clock)
//             presetn - asynchronous active-low reset
//             bus     - apb4_master_bridge_if.master (command + APB4 signals)
//  Options  : APB4_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that sees
//             TIMEOUT_CYCLES wait states is aborted with an error response.
//  Revision : 1.0 - initial release
// ============================================================================
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb4_master_bridge_if.master bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  // Keeps req_ready_o low while in reset and until the first clock after
  // release, so no request is taken in the reset-release cycle.
  logic                    ready_en_q;

  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic [2:0]              prot_q;

  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q,   err_d;

  logic                    accept;
  logic                    timeout_hit;

  assign accept = (state_q == IDLE) && ready_en_q && bus.req_valid_i;

  // --------------------------------------------------------------------------
  // Optional ACCESS-phase watchdog
  // --------------------------------------------------------------------------
`ifdef APB4_MASTER_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_q;

  // Cleared during SETUP so it starts at zero on the first ACCESS cycle;
  // counts ACCESS cycles in which the completer is still stalling.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !bus.pready_i && !timeout_hit) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt_q == CNT_MAX);
`else
  assign timeout_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State and data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prot_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      if (accept) begin
        write_q <= bus.req_write_i;
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        // Reads never carry byte enables on APB4.
        strb_q  <= bus.req_write_i ? bus.req_strb_i : '0;
        prot_q  <= bus.req_prot_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and response capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A completer answering on the timeout cycle still wins.
        if (bus.pready_i) begin
          state_d = RESP;
          rdata_d = write_q ? '0 : bus.prdata_i;
          err_d   = bus.pslverr_i;
        end else if (timeout_hit) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready_o = ready_en_q && (state_q == IDLE);

  assign bus.psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable_o   = (state_q == ACCESS);
  assign bus.paddr_o     = addr_q;
  assign bus.pwrite_o    = write_q;
  assign bus.pwdata_o    = wdata_q;
  assign bus.pstrb_o     = strb_q;
  assign bus.pprot_o     = prot_q;

  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

endmodule
`default_nettype wire
